test_controller: RTL and testbench
==================================

TEST_CONTROLLER -- requirements
Module: test_controller

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of frame generator ports sequenced.
REQ-002 SHALL have parameter STOP_TIMEOUT, default 4096, maximum cycles to wait for generators to go idle after stop.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_start  input  1  single-cycle request to begin a test.
REQ-006 SHALL have port cmd_abort  input  1  single-cycle request to end the running test early.
REQ-007 SHALL have port duration  input  32  RUN length in clk cycles, sampled on accepted cmd_start.
REQ-008 SHALL have port drain_cycles  input  16  post-stop wait for in-flight RX frames, sampled on accepted cmd_start.
REQ-009 SHALL have port port_enable  input  NUM_PORTS  per-port enable (port_config.enable), sampled on accepted cmd_start.
REQ-010 SHALL have port gen_idle  input  NUM_PORTS  per-port generator idle (no frame in progress).
REQ-011 SHALL have port gen_start  output  NUM_PORTS  per-port start pulse to frame generators.
REQ-012 SHALL have port gen_stop  output  NUM_PORTS  per-port stop pulse to frame generators.
REQ-013 SHALL have port stats_clear  output  1  pulse clearing all port counters.
REQ-014 SHALL have port stats_freeze  output  1  level; counters hold while high.
REQ-015 SHALL have ports busy, done, cmd_err  output  1 each  status: test active / result valid / start rejected (pulse).
REQ-016 SHALL have ports aborted, stop_timeout  output  1 each  sticky result flags, cleared on next accepted start.
REQ-017 SHALL have port elapsed  output  32  cycles spent in RUN for current/last test.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, RUN, STOPPING, DRAIN, DONE.
REQ-019 cmd_start SHALL be accepted only in IDLE or DONE, when duration != 0 and port_enable != 0, and cmd_abort is low; accept latches duration, drain_cycles, port_enable (snapshot) and moves to CLEAR.
REQ-020 cmd_start in IDLE/DONE with duration == 0 or port_enable == 0 SHALL pulse cmd_err for one cycle and leave state unchanged; cmd_start in other states SHALL be ignored without cmd_err.
REQ-021 CLEAR SHALL last exactly one cycle with stats_clear = 1, elapsed cleared to 0, aborted/stop_timeout cleared, then move to RUN.
REQ-022 On the first RUN cycle gen_start SHALL equal snapshot for exactly one cycle; elapsed SHALL increment every RUN cycle.
REQ-023 RUN SHALL last exactly duration cycles (elapsed reaches duration), then move to STOPPING.
REQ-024 cmd_abort in CLEAR or RUN SHALL move to STOPPING next cycle and set aborted; elapsed holds its value; in other states it is ignored.
REQ-025 On the first STOPPING cycle gen_stop SHALL equal snapshot for one cycle; gen_start and gen_stop SHALL never be high in the same cycle.
REQ-026 STOPPING SHALL move to DRAIN when (gen_idle & snapshot) == snapshot, evaluated from the second STOPPING cycle, or after STOP_TIMEOUT cycles, setting stop_timeout.
REQ-027 DRAIN SHALL last drain_cycles cycles; drain_cycles == 0 SHALL go to DONE on the next cycle.
REQ-028 DONE SHALL hold done = 1 and stats_freeze = 1 until an accepted cmd_start.
REQ-029 busy SHALL be 1 in CLEAR, RUN, STOPPING, DRAIN; 0 otherwise.
REQ-030 elapsed SHALL saturate at 32'hFFFFFFFF (unreachable for valid duration, still required).

Reset
REQ-031 rst SHALL force IDLE in the same cycle regardless of state, including mid-RUN.
REQ-032 Reset values: gen_start, gen_stop, stats_clear, cmd_err, busy, done, aborted, stop_timeout, stats_freeze = 0; elapsed = 0; snapshot = 0.

Structure
REQ-033 State enum and STOP_TIMEOUT default SHALL be in tester_common package alongside port_config_t.
REQ-034 Single sub-module down_counter (load, enable, zero flag) SHALL be used for RUN, STOPPING timeout, and DRAIN counting.

Verification
REQ-035 duration=100, drain=10, port_enable=4'b0101, gen_idle high -> gen_start=0101 one cycle, gen_stop=0101 after 100 RUN cycles, done after 10 drain cycles, elapsed=100.
REQ-036 duration=0 or port_enable=0 on cmd_start -> cmd_err one-cycle pulse, state stays IDLE, no gen_start.
REQ-037 duration=1000, cmd_abort at RUN cycle 37 -> gen_stop next cycle, aborted=1, elapsed=37.
REQ-038 gen_idle[2]=0 held forever, port_enable=4'b0100 -> stop_timeout=1 after 4096 STOPPING cycles, then DRAIN, DONE.
REQ-039 rst asserted mid-RUN -> next cycle IDLE, all outputs at reset values; fresh cmd_start runs normally.
REQ-040 cmd_start from DONE -> stats_clear pulse, aborted/stop_timeout cleared, new snapshot used.

Source files
------------

// File: rtl/test_controller_pkg.sv
// Shared types and defaults for the traffic tester control path.
package tester_common;

    localparam int unsigned STOP_TIMEOUT_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_STOPPING,
        ST_DRAIN,
        ST_DONE
    } test_state_t;

    typedef struct packed {
        logic enable;
    } port_config_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/test_controller_down_counter.sv
// Loadable down counter with a zero flag; holds at zero.
module down_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/test_controller.sv
// Test sequencer: clears stats, starts generators for a fixed run, stops them,
// waits for idle and RX drain, then holds results until the next start.
module test_controller
    import tester_common::*;
#(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned STOP_TIMEOUT = STOP_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic [31:0]          duration,
    input  logic [15:0]          drain_cycles,
    input  logic [NUM_PORTS-1:0] port_enable,
    input  logic [NUM_PORTS-1:0] gen_idle,
    output logic [NUM_PORTS-1:0] gen_start,
    output logic [NUM_PORTS-1:0] gen_stop,
    output logic                 stats_clear,
    output logic                 stats_freeze,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err,
    output logic                 aborted,
    output logic                 stop_timeout,
    output logic [31:0]          elapsed
);

    localparam logic [31:0] STOP_LOAD = 32'(STOP_TIMEOUT - 1);

    test_state_t                     state_q, state_d;
    logic                            entered_q;
    logic [31:0]                     duration_q;
    logic [15:0]                     drain_q;
    port_config_t [NUM_PORTS-1:0]    cfg_q;
    logic [NUM_PORTS-1:0]            snapshot;
    logic [31:0]                     elapsed_q;
    logic                            aborted_q;
    logic                            timeout_q;
    logic                            cmd_err_q;

    logic                            can_start;
    logic                            cfg_valid;
    logic                            accept;
    logic                            reject;
    logic                            all_idle;
    logic                            cnt_load;
    logic [31:0]                     cnt_value;
    logic                            cnt_en;
    logic                            cnt_zero;
    logic                            abort_set;
    logic                            timeout_set;
    logic [31:0]                     drain_load;

    assign snapshot  = cfg_q;
    assign can_start = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign cfg_valid = (duration != '0) && (port_enable != '0);
    assign accept    = cmd_start && can_start && cfg_valid && !cmd_abort;
    assign reject    = cmd_start && can_start && !cfg_valid;
    assign all_idle  = ((gen_idle & snapshot) == snapshot);

    // A zero drain still spends one cycle in DRAIN before DONE.
    assign drain_load = (drain_q == '0) ? '0 : {16'd0, drain_q} - 32'd1;

    down_counter #(.WIDTH(32)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .enable     (cnt_en),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        cnt_load    = 1'b0;
        cnt_value   = '0;
        cnt_en      = 1'b0;
        abort_set   = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                cnt_load = 1'b1;
                if (cmd_abort) begin
                    state_d   = ST_STOPPING;
                    abort_set = 1'b1;
                    cnt_value = STOP_LOAD;
                end else begin
                    state_d   = ST_RUN;
                    cnt_value = duration_q - 32'd1;
                end
            end
            ST_RUN: begin
                if (cmd_abort || cnt_zero) begin
                    state_d   = ST_STOPPING;
                    abort_set = cmd_abort;
                    cnt_load  = 1'b1;
                    cnt_value = STOP_LOAD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_STOPPING: begin
                // Idle is only trusted once the stop pulse has been seen.
                if ((!entered_q && all_idle) || cnt_zero) begin
                    state_d     = ST_DRAIN;
                    timeout_set = !(!entered_q && all_idle);
                    cnt_load    = 1'b1;
                    cnt_value   = drain_load;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_zero) state_d = ST_DONE;
                else          cnt_en  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            entered_q  <= 1'b0;
            duration_q <= '0;
            drain_q    <= '0;
            cfg_q      <= '0;
            elapsed_q  <= '0;
            aborted_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            entered_q <= (state_d != state_q);
            cmd_err_q <= reject;
            if (accept) begin
                duration_q <= duration;
                drain_q    <= drain_cycles;
                cfg_q      <= port_enable;
                elapsed_q  <= '0;
                aborted_q  <= 1'b0;
                timeout_q  <= 1'b0;
            end
            if ((state_q == ST_RUN) && !cmd_abort) elapsed_q <= sat_inc(elapsed_q);
            if (abort_set)   aborted_q <= 1'b1;
            if (timeout_set) timeout_q <= 1'b1;
        end
    end

    assign gen_start    = ((state_q == ST_RUN) && entered_q) ? snapshot : '0;
    assign gen_stop     = ((state_q == ST_STOPPING) && entered_q) ? snapshot : '0;
    assign stats_clear  = (state_q == ST_CLEAR);
    assign stats_freeze = (state_q == ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign busy         = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                          (state_q == ST_STOPPING) || (state_q == ST_DRAIN);
    assign cmd_err      = cmd_err_q;
    assign aborted      = aborted_q;
    assign stop_timeout = timeout_q;
    assign elapsed      = elapsed_q;

endmodule

// File: tb/tb_test_controller.sv
// Directed bench for test_controller: normal run, rejects, abort, timeout, restart, reset.
module tb_test_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic        cmd_abort;
    logic [31:0] duration;
    logic [15:0] drain_cycles;
    logic [3:0]  port_enable;
    logic [3:0]  gen_idle;
    logic [3:0]  gen_start;
    logic [3:0]  gen_stop;
    logic        stats_clear;
    logic        stats_freeze;
    logic        busy;
    logic        done;
    logic        cmd_err;
    logic        aborted;
    logic        stop_timeout;
    logic [31:0] elapsed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    test_controller #(.NUM_PORTS(4), .STOP_TIMEOUT(4096)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_start    (cmd_start),
        .cmd_abort    (cmd_abort),
        .duration     (duration),
        .drain_cycles (drain_cycles),
        .port_enable  (port_enable),
        .gen_idle     (gen_idle),
        .gen_start    (gen_start),
        .gen_stop     (gen_stop),
        .stats_clear  (stats_clear),
        .stats_freeze (stats_freeze),
        .busy         (busy),
        .done         (done),
        .cmd_err      (cmd_err),
        .aborted      (aborted),
        .stop_timeout (stop_timeout),
        .elapsed      (elapsed)
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [46:0] outs;
        rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
        duration = '0; drain_cycles = '0; port_enable = '0; gen_idle = 4'hF;
        step; step;
        outs = {gen_start, gen_stop, stats_clear, stats_freeze, busy, done,
                cmd_err, aborted, stop_timeout, elapsed};
        total++;
        if (outs !== 47'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_reject;
        duration = 32'd0; port_enable = 4'hF; drain_cycles = 16'd3; cmd_start = 1'b1;
        step; cmd_start = 1'b0;
        total++;
        if ({cmd_err, busy, stats_clear} !== 3'b100) begin
            bad++; $display("FAIL reject_dur0_err: got %b want 100", {cmd_err, busy, stats_clear});
        end
        step;
        total++;
        if ({cmd_err, busy, done, gen_start} !== 7'b0) begin
            bad++; $display("FAIL reject_dur0_after: got %b want 0", {cmd_err, busy, done, gen_start});
        end
        duration = 32'd5; port_enable = 4'h0; cmd_start = 1'b1;
        step; cmd_start = 1'b0;
        total++;
        if ({cmd_err, busy, stats_clear} !== 3'b100) begin
            bad++; $display("FAIL reject_en0_err: got %b want 100", {cmd_err, busy, stats_clear});
        end
        step;
        total++;
        if ({cmd_err, busy, gen_start} !== 6'b0) begin
            bad++; $display("FAIL reject_en0_after: got %b want 0", {cmd_err, busy, gen_start});
        end
        // start together with abort is neither accepted nor flagged
        port_enable = 4'hF; cmd_start = 1'b1; cmd_abort = 1'b1;
        step; cmd_start = 1'b0; cmd_abort = 1'b0;
        step;
        total++;
        if ({cmd_err, busy, stats_clear, gen_start} !== 7'b0) begin
            bad++; $display("FAIL start_with_abort: got %b want 0", {cmd_err, busy, stats_clear, gen_start});
        end
    endtask

    task automatic test_basic_run;
        int n;
        int extra_starts;
        duration = 32'd100; drain_cycles = 16'd10; port_enable = 4'b0101; gen_idle = 4'hF;
        cmd_start = 1'b1;
        step; cmd_start = 1'b0;
        total++;
        if ({stats_clear, busy, gen_start, elapsed} !== {1'b1, 1'b1, 4'b0, 32'd0}) begin
            bad++; $display("FAIL basic_clear: got clr=%b busy=%b gs=%b el=%0d want 1 1 0000 0",
                            stats_clear, busy, gen_start, elapsed);
        end
        step;
        total++;
        if ({gen_start, stats_clear, elapsed} !== {4'b0101, 1'b0, 32'd0}) begin
            bad++; $display("FAIL basic_gen_start: got gs=%b clr=%b el=%0d want 0101 0 0",
                            gen_start, stats_clear, elapsed);
        end
        n = 0; extra_starts = 0;
        while (gen_stop === 4'b0 && n < 300) begin
            step; n++;
            if (gen_start !== 4'b0) extra_starts++;
        end
        total++;
        if (n != 100) begin
            bad++; $display("FAIL basic_run_len: got %0d want 100", n);
        end
        total++;
        if (extra_starts != 0) begin
            bad++; $display("FAIL basic_start_once: got %0d extra want 0", extra_starts);
        end
        total++;
        if ({gen_stop, gen_start, elapsed} !== {4'b0101, 4'b0, 32'd100}) begin
            bad++; $display("FAIL basic_gen_stop: got gp=%b gs=%b el=%0d want 0101 0000 100",
                            gen_stop, gen_start, elapsed);
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            step; n++;
        end
        total++;
        if (n != 12) begin
            bad++; $display("FAIL basic_stop_drain_len: got %0d want 12", n);
        end
        total++;
        if ({stats_freeze, busy, aborted, stop_timeout, gen_stop, elapsed} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 32'd100}) begin
            bad++; $display("FAIL basic_done_state: got frz=%b busy=%b ab=%b to=%b gp=%b el=%0d want 1 0 0 0 0000 100",
                            stats_freeze, busy, aborted, stop_timeout, gen_stop, elapsed);
        end
        step; step;
        total++;
        if ({done, stats_freeze} !== 2'b11) begin
            bad++; $display("FAIL basic_done_hold: got %b want 11", {done, stats_freeze});
        end
    endtask

    task automatic test_abort;
        int n;
        duration = 32'd1000; drain_cycles = 16'd0; port_enable = 4'b0011;
        cmd_start = 1'b1;
        step; cmd_start = 1'b0;
        step;
        repeat (37) step;
        total++;
        if (elapsed !== 32'd37) begin
            bad++; $display("FAIL abort_pre_elapsed: got %0d want 37", elapsed);
        end
        cmd_abort = 1'b1; cmd_start = 1'b1;
        step; cmd_abort = 1'b0; cmd_start = 1'b0;
        total++;
        if ({gen_stop, gen_start, aborted, cmd_err, elapsed} !== {4'b0011, 4'b0, 1'b1, 1'b0, 32'd37}) begin
            bad++; $display("FAIL abort_stop: got gp=%b gs=%b ab=%b err=%b el=%0d want 0011 0000 1 0 37",
                            gen_stop, gen_start, aborted, cmd_err, elapsed);
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            step; n++;
        end
        total++;
        if (n != 3) begin
            bad++; $display("FAIL abort_to_done_len: got %0d want 3", n);
        end
        total++;
        if ({aborted, stop_timeout, elapsed} !== {1'b1, 1'b0, 32'd37}) begin
            bad++; $display("FAIL abort_done_flags: got ab=%b to=%b el=%0d want 1 0 37",
                            aborted, stop_timeout, elapsed);
        end
        cmd_abort = 1'b1;
        step; cmd_abort = 1'b0;
        total++;
        if ({done, busy, aborted, gen_stop} !== {1'b1, 1'b0, 1'b1, 4'b0}) begin
            bad++; $display("FAIL abort_in_done_ignored: got dn=%b busy=%b ab=%b gp=%b want 1 0 1 0000",
                            done, busy, aborted, gen_stop);
        end
    endtask

    task automatic test_restart_from_done;
        int n;
        duration = 32'd3; drain_cycles = 16'd2; port_enable = 4'b1000;
        cmd_start = 1'b1;
        step; cmd_start = 1'b0;
        total++;
        if ({stats_clear, aborted, done, stats_freeze, busy, elapsed} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
            bad++; $display("FAIL restart_clear: got clr=%b ab=%b dn=%b frz=%b busy=%b el=%0d want 1 0 0 0 1 0",
                            stats_clear, aborted, done, stats_freeze, busy, elapsed);
        end
        step;
        total++;
        if (gen_start !== 4'b1000) begin
            bad++; $display("FAIL restart_gen_start: got %b want 1000", gen_start);
        end
        n = 0;
        while (gen_stop === 4'b0 && n < 50) begin
            step; n++;
        end
        total++;
        if ({gen_stop, elapsed} !== {4'b1000, 32'd3} || n != 3) begin
            bad++; $display("FAIL restart_stop: got gp=%b el=%0d len=%0d want 1000 3 3", gen_stop, elapsed, n);
        end
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            step; n++;
        end
        total++;
        if (n != 4) begin
            bad++; $display("FAIL restart_to_done_len: got %0d want 4", n);
        end
    endtask

    task automatic test_stop_timeout;
        int n;
        gen_idle = 4'b1011; duration = 32'd2; drain_cycles = 16'd1; port_enable = 4'b0100;
        cmd_start = 1'b1;
        step; cmd_start = 1'b0;
        step;
        n = 0;
        while (gen_stop === 4'b0 && n < 50) begin
            step; n++;
        end
        total++;
        if (gen_stop !== 4'b0100 || n != 2) begin
            bad++; $display("FAIL timeout_gen_stop: got gp=%b len=%0d want 0100 2", gen_stop, n);
        end
        n = 0;
        while (stop_timeout !== 1'b1 && n < 5000) begin
            step; n++;
        end
        total++;
        if (n != 4096) begin
            bad++; $display("FAIL timeout_len: got %0d want 4096", n);
        end
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++; $display("FAIL timeout_in_drain: got busy=%b dn=%b want 1 0", busy, done);
        end
        step;
        total++;
        if ({done, stop_timeout, aborted} !== 3'b110) begin
            bad++; $display("FAIL timeout_done: got dn=%b to=%b ab=%b want 1 1 0", done, stop_timeout, aborted);
        end
        gen_idle = 4'hF;
    endtask

    task automatic test_reset_mid_run;
        int n;
        logic [46:0] outs;
        duration = 32'd1000; drain_cycles = 16'd4; port_enable = 4'b1111;
        cmd_start = 1'b1;
        step; cmd_start = 1'b0;
        total++;
        if ({stop_timeout, stats_clear} !== 2'b01) begin
            bad++; $display("FAIL start_clears_timeout: got to=%b clr=%b want 0 1", stop_timeout, stats_clear);
        end
        repeat (10) step;
        rst = 1'b1;
        step;
        outs = {gen_start, gen_stop, stats_clear, stats_freeze, busy, done,
                cmd_err, aborted, stop_timeout, elapsed};
        total++;
        if (outs !== 47'd0) begin
            bad++; $display("FAIL reset_mid_run: got %h want 0", outs);
        end
        rst = 1'b0;
        duration = 32'd5; drain_cycles = 16'd1; port_enable = 4'b0010;
        cmd_start = 1'b1;
        step; cmd_start = 1'b0;
        step;
        total++;
        if (gen_start !== 4'b0010) begin
            bad++; $display("FAIL post_reset_gen_start: got %b want 0010", gen_start);
        end
        n = 0;
        while (gen_stop === 4'b0 && n < 50) begin
            step; n++;
        end
        total++;
        if ({gen_stop, elapsed} !== {4'b0010, 32'd5} || n != 5) begin
            bad++; $display("FAIL post_reset_run: got gp=%b el=%0d len=%0d want 0010 5 5", gen_stop, elapsed, n);
        end
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            step; n++;
        end
        total++;
        if (n != 3) begin
            bad++; $display("FAIL post_reset_to_done: got %0d want 3", n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_reject;
        test_basic_run;
        test_abort;
        test_restart_from_done;
        test_stop_timeout;
        test_reset_mid_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
